// File: rtl/oled_text_sequencer.sv
// Owns the 64-character screen buffer and streams it, one character at a time,
// to the OLED controller's character port using the sendData/sendDone handshake.
module oled_text_sequencer #(
  parameter int         CHARS      = 64,
  parameter int         ADDR_W     = 6,
  parameter logic [6:0] BLANK_CHAR = 7'h20
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [6:0]        wr_data,
  input  logic              clear_req,
  input  logic              refresh_req,
  output logic              busy,
  output logic              frame_done,
  output logic [6:0]        send_data,
  output logic              send_data_valid,
  input  logic              send_done
);

  typedef enum logic [2:0] {CLEAR, IDLE, FETCH, SEND, RELEASE} stateT;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CHARS - 1);

  stateT             state, stateNext;
  logic [ADDR_W-1:0] idx, idxNext;
  logic [6:0]        sendDataNext;
  logic              validNext, frameDoneNext;
  logic              pendRefresh, pendRefreshNext;
  logic              pendClear, pendClearNext;
  logic              lastIdx, hostWrite;
  logic [6:0]        charBuf [CHARS];

  assign busy      = (state != IDLE);
  assign lastIdx   = (idx == LAST_IDX);
  // A write coinciding with a clear request in IDLE is dropped, as is any write during CLEAR.
  assign hostWrite = wr_en && (state != CLEAR) && !((state == IDLE) && clear_req);

  // Buffer contents are deliberately not reset; CLEAR initialises them.
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      charBuf[idx] <= BLANK_CHAR;
    end else if (hostWrite) begin
      charBuf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= CLEAR;
      idx             <= '0;
      send_data       <= '0;
      send_data_valid <= 1'b0;
      frame_done      <= 1'b0;
      pendRefresh     <= 1'b0;
      pendClear       <= 1'b0;
    end else begin
      state           <= stateNext;
      idx             <= idxNext;
      send_data       <= sendDataNext;
      send_data_valid <= validNext;
      frame_done      <= frameDoneNext;
      pendRefresh     <= pendRefreshNext;
      pendClear       <= pendClearNext;
    end
  end

  always_comb begin
    stateNext       = state;
    idxNext         = idx;
    sendDataNext    = send_data;
    frameDoneNext   = 1'b0;
    pendRefreshNext = pendRefresh;
    pendClearNext   = pendClear;

    // Requests seen while busy are remembered once; a clear during CLEAR is redundant.
    if (state != IDLE) begin
      if (refresh_req) pendRefreshNext = 1'b1;
      if (clear_req && (state != CLEAR)) pendClearNext = 1'b1;
    end

    case (state)
      CLEAR: begin
        if (lastIdx) begin
          idxNext = '0;
          if (pendRefresh) begin
            stateNext       = FETCH;
            pendRefreshNext = 1'b0;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          idxNext = idx + 1'b1;
        end
      end
      IDLE: begin
        if (clear_req) begin
          stateNext = CLEAR;
          idxNext   = '0;
        end else if (refresh_req) begin
          stateNext = FETCH;
          idxNext   = '0;
        end
      end
      FETCH: begin
        sendDataNext = charBuf[idx];
        stateNext    = SEND;
      end
      SEND: begin
        if (send_done) stateNext = RELEASE;
      end
      RELEASE: begin
        // A pending refresh survives a pending clear, so the blank frame follows the clear.
        if (!send_done) begin
          if (lastIdx) begin
            frameDoneNext = 1'b1;
            idxNext       = '0;
            if (pendClear) begin
              stateNext     = CLEAR;
              pendClearNext = 1'b0;
            end else if (pendRefresh) begin
              stateNext       = FETCH;
              pendRefreshNext = 1'b0;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            idxNext   = idx + 1'b1;
            stateNext = FETCH;
          end
        end
      end
      default: stateNext = CLEAR;
    endcase

    validNext = (stateNext == SEND);
  end

endmodule

// File: tb/tb_oled_text_sequencer.sv
// Bench for oled_text_sequencer: a character-level screen model checks every
// streamed character, plus directed scenarios with hand-computed literals.
module tb_oled_text_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [6:0] wr_data;
  logic       clear_req;
  logic       refresh_req;
  logic       busy;
  logic       frame_done;
  logic [6:0] send_data;
  logic       send_data_valid;
  logic       send_done;

  int total = 0;
  int bad   = 0;
  int ackDelay = 2;
  int ackHold  = 2;

  logic [6:0] modelBuf  [64];
  logic [6:0] lastFrame [64];
  bit         modelPendClear = 1'b0;
  int         charCount  = 0;
  int         validRises = 0;
  int         frames     = 0;
  logic       prevValid  = 1'b0;
  logic       prevFrameDone = 1'b0;
  logic [6:0] prevData   = '0;

  typedef enum {OP_WRITE, OP_REFRESH, OP_CLEAR} opT;

  always #5 clock = ~clock;

  oled_text_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .clear_req      (clear_req),
    .refresh_req    (refresh_req),
    .busy           (busy),
    .frame_done     (frame_done),
    .send_data      (send_data),
    .send_data_valid(send_data_valid),
    .send_done      (send_done)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic blankModel();
    for (int i = 0; i < 64; i++) modelBuf[i] = 7'h20;
  endtask

  // One request or write, held for exactly one sampling edge.
  task automatic applyStimulus(input opT op, input int addr, input int data);
    @(posedge clock); #1;
    case (op)
      OP_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = addr[5:0];
        wr_data = data[6:0];
        modelBuf[addr] = data[6:0];
      end
      OP_REFRESH: refresh_req = 1'b1;
      OP_CLEAR:   clear_req   = 1'b1;
      default: ;
    endcase
    @(posedge clock); #1;
    wr_en       = 1'b0;
    refresh_req = 1'b0;
    clear_req   = 1'b0;
  endtask

  task automatic waitFrames(input int target, input int budget, input string name);
    int n = 0;
    while (frames < target && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput(name, 32'(frames >= target), 1);
  endtask

  task automatic waitChars(input int target, input int budget, input string name);
    int n = 0;
    while (charCount < target && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput(name, 32'(charCount >= target), 1);
  endtask

  // Controller stand-in: acknowledges each request after ackDelay cycles for ackHold cycles.
  initial begin
    send_done = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (send_data_valid) begin
        repeat (ackDelay) @(posedge clock);
        #1 send_done = 1'b1;
        repeat (ackHold) @(posedge clock);
        #1 send_done = 1'b0;
      end
    end
  end

  // Every new character must be the model's buffer entry at its frame position.
  always @(negedge clock) begin
    if (!reset_n) begin
      charCount     = 0;
      prevValid     = 1'b0;
      prevFrameDone = 1'b0;
      prevData      = '0;
    end else begin
      if (send_data_valid && !prevValid) begin
        checkOutput("validRiseDoneLow", 32'(send_done), 0);
        if (charCount < 64) begin
          checkOutput($sformatf("char%0d", charCount), 32'(send_data), 32'(modelBuf[charCount]));
          lastFrame[charCount] = send_data;
        end else begin
          checkOutput("extraChar", charCount, 63);
        end
        charCount++;
        validRises++;
      end else if (send_data_valid) begin
        checkOutput("dataStable", 32'(send_data), 32'(prevData));
      end
      if (frame_done) begin
        checkOutput("frameDoneSingle", 32'(prevFrameDone), 0);
        checkOutput("frameLength", charCount, 64);
        charCount = 0;
        frames++;
        if (modelPendClear) begin
          blankModel();
          modelPendClear = 1'b0;
        end
      end
      prevValid     = send_data_valid;
      prevFrameDone = frame_done;
      prevData      = send_data;
    end
  end

  initial begin
    int n;
    int f0;
    int v0;
    reset_n     = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    clear_req   = 1'b0;
    refresh_req = 1'b0;
    blankModel();

    // Reset state, then the automatic 64-cycle clear.
    repeat (3) @(posedge clock);
    #1;
    checkOutput("resetBusy", 32'(busy), 1);
    checkOutput("resetValid", 32'(send_data_valid), 0);
    checkOutput("resetData", 32'(send_data), 0);
    checkOutput("resetFrameDone", 32'(frame_done), 0);
    reset_n = 1'b1;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (busy && n < 200);
    checkOutput("clearCycles", n, 64);
    checkOutput("idleNoValid", 32'(send_data_valid), 0);

    // Blank read-back frame and request-to-valid latency.
    $display("[TB] blank frame");
    applyStimulus(OP_REFRESH, 0, 0);
    checkOutput("latencyEarly", 32'(send_data_valid), 0);
    @(posedge clock); #1;
    checkOutput("latencyValid", 32'(send_data_valid), 1);
    checkOutput("latencyData", 32'(send_data), 32'h20);
    waitFrames(1, 3000, "frame1Timeout");
    checkOutput("frame1Rises", validRises, 64);

    // Slow controller: first and last characters.
    $display("[TB] A/Z frame");
    ackDelay = 20;
    ackHold  = 3;
    applyStimulus(OP_WRITE, 0, 'h41);
    applyStimulus(OP_WRITE, 63, 'h5A);
    f0 = frames;
    v0 = validRises;
    applyStimulus(OP_REFRESH, 0, 0);
    waitFrames(f0 + 1, 5000, "frame2Timeout");
    checkOutput("frame2First", 32'(lastFrame[0]), 32'h41);
    checkOutput("frame2Last", 32'(lastFrame[63]), 32'h5A);
    checkOutput("frame2Rises", validRises - v0, 64);
    repeat (20) @(posedge clock);
    #1;
    checkOutput("frame2Single", frames, f0 + 1);

    // Writes behind and ahead of the fetch pointer.
    $display("[TB] coherency");
    ackDelay = 4;
    ackHold  = 2;
    f0 = frames;
    applyStimulus(OP_REFRESH, 0, 0);
    waitChars(7, 500, "coherWait");
    applyStimulus(OP_WRITE, 5, 'h31);
    applyStimulus(OP_WRITE, 40, 'h31);
    waitFrames(f0 + 1, 3000, "frame3Timeout");
    checkOutput("coherOld5", 32'(lastFrame[5]), 32'h20);
    checkOutput("coherNew40", 32'(lastFrame[40]), 32'h31);
    applyStimulus(OP_REFRESH, 0, 0);
    waitFrames(f0 + 2, 3000, "frame4Timeout");
    checkOutput("coherNext5", 32'(lastFrame[5]), 32'h31);

    // Several requests mid-frame collapse into one clear plus one blank frame.
    $display("[TB] pending requests");
    ackDelay = 2;
    ackHold  = 2;
    f0 = frames;
    applyStimulus(OP_REFRESH, 0, 0);
    waitChars(10, 500, "pendWait");
    applyStimulus(OP_REFRESH, 0, 0);
    applyStimulus(OP_REFRESH, 0, 0);
    applyStimulus(OP_CLEAR, 0, 0);
    modelPendClear = 1'b1;
    applyStimulus(OP_REFRESH, 0, 0);
    waitFrames(f0 + 2, 3000, "pendTimeout");
    checkOutput("pendBlank0", 32'(lastFrame[0]), 32'h20);
    checkOutput("pendBlank63", 32'(lastFrame[63]), 32'h20);
    repeat (400) @(posedge clock);
    #1;
    checkOutput("noThirdFrame", frames, f0 + 2);
    checkOutput("pendIdle", 32'(busy), 0);

    // Long acknowledge: valid must stay low until send_done falls.
    $display("[TB] long acknowledge");
    ackDelay = 3;
    ackHold  = 10;
    applyStimulus(OP_WRITE, 1, 'h42);
    f0 = frames;
    applyStimulus(OP_REFRESH, 0, 0);
    n = 0;
    while (!send_done && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("doneSeen", 32'(send_done), 1);
    @(posedge clock); #1;
    n = 0;
    while (send_done && n < 50) begin
      checkOutput("validWhileDoneHigh", 32'(send_data_valid), 0);
      @(posedge clock); #1;
      n++;
    end
    waitFrames(f0 + 1, 3000, "frame5Timeout");
    checkOutput("longAckChar1", 32'(lastFrame[1]), 32'h42);

    // Reset in the middle of a frame.
    $display("[TB] mid-frame reset");
    ackDelay = 2;
    ackHold  = 2;
    applyStimulus(OP_WRITE, 0, 'h41);
    applyStimulus(OP_REFRESH, 0, 0);
    waitChars(31, 1000, "resetWait");
    checkOutput("preResetValid", 32'(send_data_valid), 1);
    reset_n = 1'b0;
    blankModel();
    modelPendClear = 1'b0;
    #1;
    checkOutput("asyncValid", 32'(send_data_valid), 0);
    checkOutput("asyncData", 32'(send_data), 0);
    checkOutput("asyncBusy", 32'(busy), 1);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    v0 = validRises;
    f0 = frames;
    repeat (300) @(posedge clock);
    #1;
    checkOutput("postResetNoValid", validRises, v0);
    checkOutput("postResetIdle", 32'(busy), 0);
    applyStimulus(OP_REFRESH, 0, 0);
    waitFrames(f0 + 1, 3000, "frame6Timeout");
    checkOutput("postResetBlank0", 32'(lastFrame[0]), 32'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
